// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the execute-stage ALU issue controller: opcode and
// ALU-operation encodings plus the FSM state type.
package alu_issue_ctrl_pkg;

    localparam logic [7:0] OPCODE_ADD      = 8'h01;
    localparam logic [7:0] OPCODE_SUB      = 8'h02;
    localparam logic [7:0] OPCODE_MUL      = 8'h03;
    localparam logic [7:0] OPCODE_LDB      = 8'h04;
    localparam logic [7:0] OPCODE_LDW      = 8'h05;
    localparam logic [7:0] OPCODE_STB      = 8'h06;
    localparam logic [7:0] OPCODE_STW      = 8'h07;
    localparam logic [7:0] OPCODE_MOV      = 8'h08;
    localparam logic [7:0] OPCODE_BEQ      = 8'h09;
    localparam logic [7:0] OPCODE_JUMP     = 8'h0A;
    localparam logic [7:0] OPCODE_TLBWRITE = 8'h0B;
    localparam logic [7:0] OPCODE_IRET     = 8'h0C;

    localparam logic [7:0] ALUOP_NOP      = 8'h00;
    localparam logic [7:0] ALUOP_ADD      = 8'h11;
    localparam logic [7:0] ALUOP_SUB      = 8'h12;
    localparam logic [7:0] ALUOP_MUL      = 8'h13;
    localparam logic [7:0] ALUOP_LDB      = 8'h14;
    localparam logic [7:0] ALUOP_LDW      = 8'h15;
    localparam logic [7:0] ALUOP_STB      = 8'h16;
    localparam logic [7:0] ALUOP_STW      = 8'h17;
    localparam logic [7:0] ALUOP_MOV      = 8'h18;
    localparam logic [7:0] ALUOP_BEQ      = 8'h19;
    localparam logic [7:0] ALUOP_JUMP     = 8'h1A;
    localparam logic [7:0] ALUOP_TLBWRITE = 8'h1B;
    localparam logic [7:0] ALUOP_IRET     = 8'h1C;

    localparam int CNT_W = 4;

    typedef enum logic {
        ALUCTRL_ST_IDLE     = 1'b0,
        ALUCTRL_ST_MUL_BUSY = 1'b1
    } aluctrl_state_e;

endpackage

// File: rtl/alu_opdecode.sv
// Purely combinational opcode -> ALU operation table with a multiply flag
// and an unknown-opcode flag (unknown opcodes map to ALUOP_NOP).
module alu_opdecode
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 8
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic                is_mul_o,
    output logic                unknown_o
);

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        aluop_o   = ALUOP_W'(ALUOP_NOP);
        is_mul_o  = 1'b0;
        unknown_o = 1'b0;
        case (opcode_i)
            OPCODE_W'(OPCODE_ADD):      aluop_o = ALUOP_W'(ALUOP_ADD);
            OPCODE_W'(OPCODE_SUB):      aluop_o = ALUOP_W'(ALUOP_SUB);
            OPCODE_W'(OPCODE_MUL): begin
                aluop_o  = ALUOP_W'(ALUOP_MUL);
                is_mul_o = 1'b1;
            end
            OPCODE_W'(OPCODE_LDB):      aluop_o = ALUOP_W'(ALUOP_LDB);
            OPCODE_W'(OPCODE_LDW):      aluop_o = ALUOP_W'(ALUOP_LDW);
            OPCODE_W'(OPCODE_STB):      aluop_o = ALUOP_W'(ALUOP_STB);
            OPCODE_W'(OPCODE_STW):      aluop_o = ALUOP_W'(ALUOP_STW);
            OPCODE_W'(OPCODE_MOV):      aluop_o = ALUOP_W'(ALUOP_MOV);
            OPCODE_W'(OPCODE_BEQ):      aluop_o = ALUOP_W'(ALUOP_BEQ);
            OPCODE_W'(OPCODE_JUMP):     aluop_o = ALUOP_W'(ALUOP_JUMP);
            OPCODE_W'(OPCODE_TLBWRITE): aluop_o = ALUOP_W'(ALUOP_TLBWRITE);
            OPCODE_W'(OPCODE_IRET):     aluop_o = ALUOP_W'(ALUOP_IRET);
            default:                    unknown_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered ALU issue controller: decodes opcodes, sequences multi-cycle
// multiplies, honours stall/flush. Optional illegal_out via ALUCTRL_ILLEGAL_TRAP_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 8,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                ready_out,
    input  logic                stall_in,
    input  logic                flush_in,
    output logic                valid_out,
    output logic [ALUOP_W-1:0]  aluop_out,
    output logic                busy_out
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_out
`endif
);

    aluctrl_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic               busy_q, busy_d;
    logic               illegal_q, illegal_d;

    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_is_mul;
    logic               dec_unknown;
    logic               accept;

    alu_opdecode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_opdecode (
        .opcode_i  (opcode),
        .aluop_o   (dec_aluop),
        .is_mul_o  (dec_is_mul),
        .unknown_o (dec_unknown)
    );

    assign ready_out = (state_q == ALUCTRL_ST_IDLE) && !stall_in;
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        busy_d    = busy_q;
        illegal_d = illegal_q;
        if (flush_in) begin
            // aluop_out deliberately keeps its last value across a flush
            state_d   = ALUCTRL_ST_IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall_in) begin
            case (state_q)
                ALUCTRL_ST_IDLE: begin
                    valid_d   = 1'b0;
                    illegal_d = 1'b0;
                    if (accept) begin
                        if (dec_is_mul && (MUL_LAT > 1)) begin
                            state_d = ALUCTRL_ST_MUL_BUSY;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            aluop_d = ALUOP_W'(ALUOP_MUL);
                            busy_d  = 1'b1;
                        end else begin
                            aluop_d   = dec_aluop;
                            valid_d   = 1'b1;
                            illegal_d = dec_unknown;
                        end
                    end
                end
                ALUCTRL_ST_MUL_BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ALUCTRL_ST_IDLE;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = ALUCTRL_ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ALUCTRL_ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            aluop_q   <= ALUOP_W'(ALUOP_NOP);
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_out = valid_q;
    assign aluop_out = aluop_q;
    assign busy_out  = busy_q;

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
    assign illegal_out = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && !flush_in && accept && dec_unknown)
            $warning("alu_issue_ctrl: unknown opcode 0x%0h retired as NOP", opcode);
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised self-checking bench: two controllers (MUL_LAT=4 and MUL_LAT=1)
// share one stimulus stream and are compared against a transaction-level model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    logic       clk = 1'b0;
    logic       reset, valid_in, stall_in, flush_in;
    logic [7:0] opcode;

    logic       ready_o [2];
    logic       valid_o [2];
    logic [7:0] aluop_o [2];
    logic       busy_o  [2];
    logic       ill_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.OPCODE_W(8), .ALUOP_W(8), .MUL_LAT(LAT0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .opcode    (opcode),
        .ready_out (ready_o[0]),
        .stall_in  (stall_in),
        .flush_in  (flush_in),
        .valid_out (valid_o[0]),
        .aluop_out (aluop_o[0]),
        .busy_out  (busy_o[0])
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_out (ill_o[0])
`endif
    );

    alu_issue_ctrl #(.OPCODE_W(8), .ALUOP_W(8), .MUL_LAT(LAT1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .opcode    (opcode),
        .ready_out (ready_o[1]),
        .stall_in  (stall_in),
        .flush_in  (flush_in),
        .valid_out (valid_o[1]),
        .aluop_out (aluop_o[1]),
        .busy_out  (busy_o[1])
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_out (ill_o[1])
`endif
    );

`ifndef ALUCTRL_ILLEGAL_TRAP_EN
    assign ill_o[0] = 1'b0;
    assign ill_o[1] = 1'b0;
`endif

    // Reference model: a unit is either free or owes a multiply result after a
    // number of remaining unstalled busy cycles.
    int         lat       [2];
    bit         m_busy    [2];
    int         m_left    [2];
    bit         m_valid   [2];
    logic [7:0] m_aluop   [2];
    bit         m_illegal [2];
    logic [7:0] op_map [logic [7:0]];
    logic [7:0] known_ops [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]    = 1'b0;
            m_left[k]    = 0;
            m_valid[k]   = 1'b0;
            m_aluop[k]   = ALUOP_NOP;
            m_illegal[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [7:0] op,
                              input bit st, input bit fl);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_busy[k] = 1'b0; m_left[k] = 0; m_valid[k] = 1'b0;
                m_aluop[k] = ALUOP_NOP; m_illegal[k] = 1'b0;
            end else if (fl) begin
                m_busy[k] = 1'b0; m_left[k] = 0; m_valid[k] = 1'b0; m_illegal[k] = 1'b0;
            end else if (!st) begin
                if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k]  = 1'b0;
                        m_valid[k] = 1'b1;
                    end
                end else begin
                    m_valid[k]   = 1'b0;
                    m_illegal[k] = 1'b0;
                    if (v) begin
                        if (op == OPCODE_MUL && lat[k] > 1) begin
                            m_busy[k]  = 1'b1;
                            m_left[k]  = lat[k] - 1;
                            m_aluop[k] = ALUOP_MUL;
                        end else if (op_map.exists(op)) begin
                            m_valid[k] = 1'b1;
                            m_aluop[k] = op_map[op];
                        end else begin
                            m_valid[k]   = 1'b1;
                            m_aluop[k]   = ALUOP_NOP;
                            m_illegal[k] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: check registered outputs, drive inputs, check ready, advance model.
    task automatic step(input bit r, input bit v, input logic [7:0] op,
                        input bit st, input bit fl);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid_out[%0d]", k), 32'(valid_o[k]), 32'(m_valid[k]));
            check($sformatf("aluop_out[%0d]", k), 32'(aluop_o[k]), 32'(m_aluop[k]));
            check($sformatf("busy_out[%0d]", k),  32'(busy_o[k]),  32'(m_busy[k]));
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
            check($sformatf("illegal_out[%0d]", k), 32'(ill_o[k]), 32'(m_illegal[k]));
`endif
        end
        reset    = r;
        valid_in = v;
        opcode   = op;
        stall_in = st;
        flush_in = fl;
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("ready_out[%0d]", k), 32'(ready_o[k]), 32'(!m_busy[k] && !st));
        @(posedge clk);
        model_edge(r, v, op, st, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        lat[0] = LAT0;
        lat[1] = LAT1;
        op_map[OPCODE_ADD] = ALUOP_ADD;   op_map[OPCODE_SUB] = ALUOP_SUB;
        op_map[OPCODE_MUL] = ALUOP_MUL;   op_map[OPCODE_LDB] = ALUOP_LDB;
        op_map[OPCODE_LDW] = ALUOP_LDW;   op_map[OPCODE_STB] = ALUOP_STB;
        op_map[OPCODE_STW] = ALUOP_STW;   op_map[OPCODE_MOV] = ALUOP_MOV;
        op_map[OPCODE_BEQ] = ALUOP_BEQ;   op_map[OPCODE_JUMP] = ALUOP_JUMP;
        op_map[OPCODE_TLBWRITE] = ALUOP_TLBWRITE;
        op_map[OPCODE_IRET] = ALUOP_IRET;
        foreach (op_map[o]) known_ops.push_back(o);

        reset = 1'b1; valid_in = 1'b0; opcode = 8'h00; stall_in = 1'b0; flush_in = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();

        // Single-cycle ADD, then idle bubble.
        step(0, 1, OPCODE_ADD, 0, 0);
        idle(2);
        // MUL with SUBs offered while the latency-4 unit is busy.
        step(0, 1, OPCODE_MUL, 0, 0);
        step(0, 1, OPCODE_SUB, 0, 0);
        step(0, 1, OPCODE_SUB, 0, 0);
        step(0, 1, OPCODE_SUB, 0, 0);
        idle(3);
        // MUL stretched by two stall cycles.
        step(0, 1, OPCODE_MUL, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, OPCODE_ADD, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        idle(5);
        // Flush mid-multiply, with an opcode that must be dropped.
        step(0, 1, OPCODE_MUL, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, OPCODE_LDW, 0, 1);
        idle(5);
        // Unknown opcode retires as a NOP bubble.
        step(0, 1, 8'hFF, 0, 0);
        idle(2);
        // Back-to-back MULs (full rate on the latency-1 unit).
        for (int i = 0; i < 6; i++) step(0, 1, OPCODE_MUL, 0, 0);
        idle(4);
        // Reset mid-multiply.
        step(0, 1, OPCODE_MUL, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(1, 1, OPCODE_ADD, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit         r, v, st, fl;
            logic [7:0] op;
            r  = ($urandom_range(199) == 0);
            fl = ($urandom_range(19) == 0);
            st = ($urandom_range(99) < 15);
            v  = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 4)
                op = 8'($urandom_range(255));
            else if ($urandom_range(99) < 30)
                op = OPCODE_MUL;
            else
                op = known_ops[$urandom_range(known_ops.size() - 1)];
            step(r, v, op, st, fl);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
